sync_fifo_core: RTL and testbench

- Single-clock synchronous FIFO buffer between one producer and one consumer.
- Enable-qualified write and read ports, registered read data, and full/empty status flags.
- Storage is a register array addressed by binary pointers. Each pointer carries one extra wrap bit.
- Used as a generic rate-decoupling buffer inside a single clock domain.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 43 ++++
 rtl/sync_fifo_core.sv | 128 ++++++++++++
 tb/tb_sync_fifo_core.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the sync_fifo_core slice.
package sync_fifo_pkg;

  localparam int SYNC_FIFO_DATA_WIDTH = 32'sd8;
  localparam int SYNC_FIFO_DEPTH      = 32'sd16;

  // Pointer width: storage index bits plus one wrap bit.
  function automatic int sync_fifo_ptr_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Storage is deliberately not reset; only the read register is cleared.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
  parameter int DEPTH      = SYNC_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port: store incoming data at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: register the addressed entry, hold otherwise, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock synchronous FIFO with binary wrap-bit pointers.
// Optional status outputs (count, sticky overflow/underflow) are compiled in
// when the macro SYNC_FIFO_STATUS_EN is defined.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
  parameter int DEPTH      = SYNC_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
`ifdef SYNC_FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam int PTR_WIDTH = sync_fifo_ptr_width(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ZERO = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [PTR_WIDTH-1:0] wr_ptr_nxt_s;
  logic [PTR_WIDTH-1:0] rd_ptr_nxt_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;

  // Flags from registered pointers: equal means empty, wrap bits differing
  // with equal index bits means full.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
              (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
  end

  // Accept decisions: a read frees a slot so a write on a full FIFO still
  // goes through; a read on an empty FIFO never falls through.
  always_comb begin
    rd_acc_s = rd_en && !empty_s;
    wr_acc_s = wr_en && (!full_s || rd_acc_s);
  end

  // Next pointer values, advancing by one per accepted operation.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Pointer registers; reset takes priority over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[ADDR_WIDTH-1:0]),
    .wdata (din),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r[ADDR_WIDTH-1:0]),
    .rdata (dout)
  );

  assign full  = full_s;
  assign empty = empty_s;

`ifdef SYNC_FIFO_STATUS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags: a dropped write or a read on an empty FIFO latches
  // until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && !wr_acc_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign count     = wr_ptr_r - rd_ptr_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core: the stimulus thread pushes expected
// read data into a queue, a monitor thread pops and compares each cycle.
module tb_sync_fifo_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
`endif

  int tests = 0;
  int fails = 0;

  // Reference state, updated by the stimulus thread for the coming edge.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit  exp_ovf = 1'b0;
  bit  exp_unf = 1'b0;
  bit  cyc_rst = 1'b1;
  bit  cyc_rd  = 1'b0;
  bit  cyc_ovf = 1'b0;
  bit  cyc_unf = 1'b0;
  int  cyc_cnt = 0;

  sync_fifo_core dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .din       (din),
    .dout      (dout),
    .full      (full),
`ifdef SYNC_FIFO_STATUS_EN
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the next edge must do.
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit rs);
    bit ra;
    bit wa;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    rst   = rs;
    ra    = 1'b0;
    if (rs) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      ra = r && (model_q.size() != 0);
      wa = w && ((model_q.size() < 16) || ra);
      if (r && model_q.size() == 0) exp_unf = 1'b1;
      if (w && !wa) exp_ovf = 1'b1;
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
    end
    cyc_rst = rs;
    cyc_rd  = ra;
    cyc_cnt = model_q.size();
    cyc_ovf = exp_ovf;
    cyc_unf = exp_unf;
  endtask

  // Monitor: after every edge compare dout and flags against the scoreboard.
  initial begin
    logic [7:0] exp_dout;
    bit l_rst, l_rd, l_ovf, l_unf;
    int l_cnt;
    exp_dout = 8'h00;
    forever begin
      @(posedge clk);
      l_rst = cyc_rst;
      l_rd  = cyc_rd;
      l_cnt = cyc_cnt;
      l_ovf = cyc_ovf;
      l_unf = cyc_unf;
      #1;
      if (l_rst) begin
        exp_dout = 8'h00;
      end else if (l_rd) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: read with no expected data at %0t", $time);
        end else begin
          exp_dout = exp_q.pop_front();
        end
      end
      chk("dout", {24'h0, dout}, {24'h0, exp_dout});
      chk("empty", {31'h0, empty}, {31'h0, (l_cnt == 0)});
      chk("full", {31'h0, full}, {31'h0, (l_cnt == 16)});
`ifdef SYNC_FIFO_STATUS_EN
      chk("count", {27'h0, count}, l_cnt);
      chk("overflow", {31'h0, overflow}, {31'h0, l_ovf});
      chk("underflow", {31'h0, underflow}, {31'h0, l_unf});
`endif
    end
  end

  // Directed stimulus.
  initial begin
    logic [7:0] dat;

    // Reset held for two cycles.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Underflow: read on empty after reset, dout stays 0.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);

    // Overflow: write while full is dropped.
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Simultaneous write+read on full: 0x01 comes out, 0x77 goes in last.
    step(1'b1, 1'b1, 8'h77, 1'b0);

    // Drain: 0x02..0x10 then 0x77, plus one extra read on empty.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Write+read on empty: only the write is accepted.
    step(1'b1, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Wrap-around: interleaved traffic at 2..3 entries of occupancy.
    dat = 8'h20;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, dat, 1'b0);
      dat = dat + 8'h01;
    end
    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0: begin step(1'b1, 1'b0, dat, 1'b0); dat = dat + 8'h01; end
        1: begin step(1'b1, 1'b1, dat, 1'b0); dat = dat + 8'h01; end
        default: step(1'b0, 1'b1, 8'h00, 1'b0);
      endcase
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Reset mid-operation with requests asserted: contents discarded.
    step(1'b1, 1'b0, 8'h91, 1'b0);
    step(1'b1, 1'b0, 8'h92, 1'b0);
    step(1'b1, 1'b1, 8'h93, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
